// File: rtl/debug_monitor_mem_access.sv
// debug_monitor_mem_access: turns JTAG debug-slave memory commands into single-word Avalon-MM
// reads/writes with an auto-incrementing word address and a stall timeout.
module debug_monitor_mem_access #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    input  logic        take_no_action_ocimem_a,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);
    typedef enum logic [1:0] {IDLE, RD, WR} state_t;
    state_t state, state_n;
    logic [29:0] waddr;
    logic [15:0] cnt;
    logic cmd_a, cmd_b, cmd_r, any_cmd, idle, done, tout;
    logic jdo_unused;
    assign jdo_unused = ^{jdo[37:35], jdo[33:32]};
    assign idle = state == IDLE;
    assign cmd_a = take_action_ocimem_a;
    assign cmd_b = take_action_ocimem_b & ~cmd_a;
    assign cmd_r = take_no_action_ocimem_a & ~cmd_a & ~take_action_ocimem_b;
    assign any_cmd = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign done = ~idle & ~avm_waitrequest;
    assign tout = ~idle & avm_waitrequest & (cnt == 16'(TIMEOUT_CYCLES - 1));
    always_comb begin
        state_n = state;
        if (idle)
            state_n = cmd_a ? (jdo[34] ? RD : IDLE) : cmd_b ? WR : cmd_r ? RD : IDLE;
        else
            state_n = (done | tout) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            waddr         <= '0;
            cnt           <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
            avm_writedata <= '0;
        end else begin
            state         <= state_n;
            cnt           <= idle ? 16'd0 : cnt + 16'd1;
            monitor_error <= idle ? (any_cmd ? 1'b0 : monitor_error) : ((any_cmd | tout) ? 1'b1 : monitor_error);
            waddr         <= (idle & cmd_a) ? jdo[29:0] : done ? waddr + 30'd1 : waddr;
            avm_writedata <= (idle & cmd_b) ? jdo[31:0] : avm_writedata;
            MonDReg       <= (done & (state == RD)) ? avm_readdata : MonDReg;
        end
    end
    assign avm_address    = {waddr, 2'b00};
    assign avm_read       = state == RD;
    assign avm_write      = state == WR;
    assign avm_byteenable = 4'hF;
    assign monitor_ready  = idle;
endmodule

// File: tb/tb_debug_monitor_mem_access.sv
// tb_debug_monitor_mem_access: scoreboard bench; expected Avalon transfers are queued when a
// command is issued and matched when the slave completes them.
module tb_debug_monitor_mem_access;
    logic        clk = 0, reset = 1;
    logic [37:0] jdo = '0;
    logic        ta_a = 0, ta_b = 0, tn_a = 0;
    logic [31:0] mon_d_reg, avm_address, avm_writedata, avm_readdata = '0;
    logic        monitor_ready, monitor_error, avm_read, avm_write, avm_waitrequest = 0;
    logic [3:0]  avm_byteenable;
    typedef struct {logic wr; logic [31:0] addr; logic [31:0] data;} xfer_t;
    xfer_t sb[$];
    int total = 0, bad = 0, run = 0, last_len = 0, req_seen = 0;
    logic prev_req = 0, prev_wait = 0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    always #5 clk = ~clk;
    debug_monitor_mem_access #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .jdo(jdo),
        .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tn_a),
        .MonDReg(mon_d_reg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic cmd(input logic a, input logic b, input logic r, input logic [37:0] j);
        ta_a = a; ta_b = b; tn_a = r; jdo = j;
        tick();
        ta_a = 0; ta_b = 0; tn_a = 0; jdo = '0;
    endtask
    task automatic push(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        xfer_t x;
        x.wr = wr; x.addr = addr; x.data = data;
        sb.push_back(x);
    endtask
    always @(negedge clk) begin
        xfer_t x;
        logic req;
        req = avm_read | avm_write;
        if (avm_read & avm_write) chk("rw_excl", 32'd1, 32'd0);
        if (avm_byteenable !== 4'hF) chk("byteen", 32'(avm_byteenable), 32'hF);
        if (req && prev_req && prev_wait) begin
            chk("addr_hold", avm_address, prev_addr);
            if (avm_write) chk("wdata_hold", avm_writedata, prev_data);
        end
        if (req && !avm_waitrequest) begin
            if (sb.size() == 0) chk("sb_unexpected", 32'd1, 32'd0);
            else begin
                x = sb.pop_front();
                chk("sb_wr", 32'(avm_write), 32'(x.wr));
                chk("sb_addr", avm_address, x.addr);
                if (x.wr) chk("sb_wdata", avm_writedata, x.data);
            end
        end
        if (req) begin run++; req_seen++; end
        else if (run != 0) begin last_len = run; run = 0; end
        prev_req = req; prev_wait = avm_waitrequest;
        prev_addr = avm_address; prev_data = avm_writedata;
    end
    initial begin
        logic [31:0] rd_vals [3];
        rd_vals = '{32'h11111111, 32'h22222222, 32'h33333333};
        tick(2);
        reset = 0;
        chk("rst_mon", mon_d_reg, 0);
        chk("rst_ready", 32'(monitor_ready), 1);
        chk("rst_err", 32'(monitor_error), 0);
        chk("rst_rd", 32'(avm_read), 0);
        chk("rst_wr", 32'(avm_write), 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_wdata", avm_writedata, 0);
        tick(20);
        chk("idle_quiet", 32'(req_seen), 0);
        cmd(1, 0, 0, 38'h100);
        chk("load_ready", 32'(monitor_ready), 1);
        chk("load_addr", avm_address, 32'h400);
        for (int i = 0; i < 3; i++) begin
            avm_readdata = rd_vals[i];
            avm_waitrequest = 0;
            push(0, 32'h400 + 32'(4 * i), rd_vals[i]);
            cmd(0, 0, 1, '0);
            chk("rd_busy", 32'(monitor_ready), 0);
            chk("rd_req", 32'(avm_read), 1);
            tick();
            chk("rd_ready", 32'(monitor_ready), 1);
            chk("rd_data", mon_d_reg, rd_vals[i]);
        end
        chk("rd_next_addr", avm_address, 32'h40C);
        push(1, 32'h40C, 32'hCAFEF00D);
        avm_waitrequest = 1;
        cmd(0, 1, 0, 38'hCAFEF00D);
        tick(3);
        chk("wr_stall_req", 32'(avm_write), 1);
        avm_waitrequest = 0;
        tick();
        chk("wr_ready", 32'(monitor_ready), 1);
        chk("wr_next_addr", avm_address, 32'h410);
        tick();
        chk("wr_len", 32'(last_len), 4);
        avm_waitrequest = 1;
        cmd(0, 0, 1, '0);
        tick(7);
        chk("to_still_req", 32'(avm_read), 1);
        tick();
        chk("to_rd_drop", 32'(avm_read), 0);
        chk("to_ready", 32'(monitor_ready), 1);
        chk("to_err", 32'(monitor_error), 1);
        chk("to_mon", mon_d_reg, 32'h33333333);
        chk("to_addr", avm_address, 32'h410);
        tick();
        chk("to_len", 32'(last_len), 8);
        avm_waitrequest = 0;
        cmd(1, 0, 0, 38'h104);
        chk("err_clear", 32'(monitor_error), 0);
        avm_waitrequest = 1;
        avm_readdata = 32'h44444444;
        push(0, 32'h410, 32'h44444444);
        cmd(0, 0, 1, '0);
        tick();
        cmd(0, 1, 0, 38'hDEADBEEF);
        chk("ovr_err", 32'(monitor_error), 1);
        chk("ovr_still_rd", 32'(avm_read), 1);
        avm_waitrequest = 0;
        tick();
        chk("ovr_mon", mon_d_reg, 32'h44444444);
        chk("ovr_addr", avm_address, 32'h414);
        chk("ovr_err_sticky", 32'(monitor_error), 1);
        chk("ovr_wdata", avm_writedata, 32'hCAFEF00D);
        avm_readdata = 32'h55555555;
        push(0, 32'hFFFFFFFC, 32'h55555555);
        cmd(1, 0, 0, (38'd1 << 34) | 38'h3FFFFFFF);
        chk("wrap_rd", 32'(avm_read), 1);
        tick();
        chk("wrap_addr", avm_address, 32'h0);
        chk("wrap_mon", mon_d_reg, 32'h55555555);
        chk("wrap_err", 32'(monitor_error), 0);
        avm_waitrequest = 1;
        cmd(0, 1, 0, 38'h12345678);
        tick();
        chk("mid_wr", 32'(avm_write), 1);
        reset = 1;
        tick();
        reset = 0;
        chk("mid_wr_drop", 32'(avm_write), 0);
        chk("mid_ready", 32'(monitor_ready), 1);
        chk("mid_wdata", avm_writedata, 0);
        avm_waitrequest = 0;
        cmd(1, 1, 0, 38'h200);
        chk("pri_wr", 32'(avm_write), 0);
        chk("pri_ready", 32'(monitor_ready), 1);
        chk("pri_addr", avm_address, 32'h800);
        chk("pri_wdata", avm_writedata, 0);
        tick(2);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/debug_monitor_mem_access.md
# debug_monitor_mem_access

Sysclk-domain engine directly downstream of the Nios II JTAG debug slave wrapper. It consumes that block's `jdo` payload and one-cycle `take_action_ocimem_a`, `take_action_ocimem_b` and `take_no_action_ocimem_a` strobes, and turns them into single-word Avalon-MM master reads and writes with an auto-incrementing address. It returns `MonDReg`, `monitor_ready` and `monitor_error` to the wrapper's scan chain, so a debugger can stream memory contents without CPU involvement.

## Interface
- `TIMEOUT_CYCLES`, default 256: maximum cycles a request may stall on `avm_waitrequest` before it is abandoned (range 2..65535).
- `clk` in 1: system clock; only clock.
- `reset` in 1: synchronous, active-high reset.
- `jdo` in 38: command payload from the debug slave; valid in the strobe cycle only.
- `take_action_ocimem_a` in 1: load-address command strobe.
- `take_action_ocimem_b` in 1: write-word command strobe.
- `take_no_action_ocimem_a` in 1: read-word command strobe.
- `MonDReg` out 32: last read data.
- `monitor_ready` out 1: engine idle and able to accept a command.
- `monitor_error` out 1: sticky error flag.
- `avm_address` out 32: byte address, with bits [1:0] = 0.
- `avm_read` out 1: Avalon read request.
- `avm_write` out 1: Avalon write request.
- `avm_writedata` out 32: write data.
- `avm_byteenable` out 4: constant 4'hF.
- `avm_readdata` in 32: read data, valid in the cycle where `avm_read`=1 and `avm_waitrequest`=0.
- `avm_waitrequest` in 1: slave stall.

## Operation
- Internal 30-bit word-address register `waddr`; `avm_address = {waddr, 2'b00}`.
- States: IDLE, RD, WR.
- **Command priority:** if several strobes are high in the same cycle, the priority is `take_action_ocimem_a` > `take_action_ocimem_b` > `take_no_action_ocimem_a`. The others are discarded with no error.
- **Command in IDLE.** Every accepted command clears `monitor_error`.
  - `take_action_ocimem_a`: `waddr` <= `jdo[29:0]`. If `jdo[34]`=1, go to RD at the new address; otherwise stay in IDLE.
  - `take_action_ocimem_b`: latch `avm_writedata` <= `jdo[31:0]`, then go to WR.
  - `take_no_action_ocimem_a`: go to RD.
- **RD:** `avm_read`=1 until `avm_waitrequest`=0. In that cycle: `MonDReg` <= `avm_readdata`, `waddr` <= `waddr`+1, state returns to IDLE.
- **WR:** `avm_write`=1 until `avm_waitrequest`=0. In that cycle: `waddr` <= `waddr`+1, state returns to IDLE.
- **Address wrap:** `waddr` increments modulo 2^30, so 0x3FFFFFFF goes to 0.
- **Timeout:** a counter clears on entry to RD or WR and increments on every stalled cycle. When it reaches `TIMEOUT_CYCLES`-1 with `avm_waitrequest` still 1:
  - drop `avm_read`/`avm_write` and return to IDLE;
  - set `monitor_error`=1;
  - leave `MonDReg` and `waddr` unchanged, so the host can retry.
- **Overrun:** any strobe arriving while in RD or WR is discarded and sets `monitor_error`=1. The transfer in flight is unaffected.
- `monitor_ready` = 1 exactly when the state is IDLE (registered).

## Timing
- Reset values: `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0, `avm_read`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0, `waddr`=0, state IDLE.
- Reset mid-transfer: at the next edge, `avm_read`/`avm_write` go to 0 and all registers take their reset values. The pending Avalon access is abandoned.
- A strobe at edge N gives `avm_read`/`avm_write`=1 and `monitor_ready`=0 from N+1.
- With zero-wait slaves, the request is high for exactly one cycle; `MonDReg`/`waddr` update and `monitor_ready`=1 at N+2. This is the minimum command-to-command spacing of 2 cycles.
- Avalon rules while a request is stalled: `avm_address`, `avm_writedata` and `avm_read`/`avm_write` hold stable.
- `avm_read` and `avm_write` are never high together.
- The timeout path gives `monitor_ready`=1 and `monitor_error`=1 exactly `TIMEOUT_CYCLES` cycles after the request first asserts.
- No combinational path from any input to any output.

## Test plan
- **Reset and idle:** assert `reset` for 2 cycles -> all outputs at their reset values; no Avalon activity for 20 idle cycles.
- **Load address, then stream reads:** `ocimem_a` with `jdo[29:0]`=0x100 and `jdo[34]`=0, then three `no_action_ocimem_a` strobes; slave returns 0x11111111, 0x22222222, 0x33333333 -> addresses 0x400, 0x404, 0x408; final `MonDReg`=0x33333333.
- **Write with waitrequest:**
  - stimulus: `ocimem_b` with `jdo[31:0]`=0xCAFEF00D; slave stalls 3 cycles;
  - required: `avm_write` high for 4 cycles with address and data stable, then `monitor_ready`=1 and the next address is +4.
- **Timeout:** `TIMEOUT_CYCLES`=8, `avm_waitrequest` held at 1 -> `avm_read` high for exactly 8 cycles; `monitor_error`=1; `MonDReg` and address unchanged; the next accepted command clears `monitor_error`.
- **Overrun and wrap:**
  - overrun: a strobe during a stalled read -> `monitor_error`=1 and the read completes normally;
  - wrap: load `waddr`=0x3FFFFFFF, then read -> the next `avm_address` is 0x00000000.
- **Reset mid-operation and priority:**
  - reset mid-operation: `reset` asserted during a stalled write -> `avm_write`=0 at the next edge;
  - priority: `ocimem_a` and `ocimem_b` in the same cycle -> only the address load takes effect.
